// File: rtl/pc_ras_pkg.sv
// pc_ras_pkg: shared address width, enable levels, default vectors and the
// action-select encoding used by the program counter and its RAS.
// Helper select_action() resolves the control priority trap > call > jmp > ret > inc.
`timescale 1ns/1ps
package pc_ras_pkg;

  localparam int PC_ADDR_WIDTH = 32;
  typedef logic [PC_ADDR_WIDTH-1:0] pc_addr_vector_t;

  localparam logic ENABLE  = 1'b1;
  localparam logic DISABLE = 1'b0;

  localparam pc_addr_vector_t DEF_RESET_VECTOR = 32'h0000_0000;
  localparam pc_addr_vector_t DEF_TRAP_VECTOR  = 32'h0000_0010;

  typedef enum logic [2:0] {
    ACT_HOLD,
    ACT_TRAP,
    ACT_CALL,
    ACT_JMP,
    ACT_RET,
    ACT_INC
  } act_e;

  // Trap ignores en; everything else needs en asserted.
  function automatic act_e select_action(input logic en, input logic trap,
                                         input logic call, input logic jmp,
                                         input logic ret);
    if (trap)              return ACT_TRAP;
    else if (en != ENABLE) return ACT_HOLD;
    else if (call)         return ACT_CALL;
    else if (jmp)          return ACT_JMP;
    else if (ret)          return ACT_RET;
    else                   return ACT_INC;
  endfunction

endpackage

// File: rtl/pc_ras_stack.sv
// ras_stack: circular LIFO of return addresses; pushing when full overwrites the oldest entry.
// Latency: push/pop take effect on the clock edge; top/empty/full derive from registered state.
// Backpressure: none; pop when empty is ignored, push when full sets sticky ovf.
// Ports: clk, reset (async active-low), push, pop, data_in -> top, empty, full, ovf.
`timescale 1ns/1ps
module ras_stack
  import pc_ras_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] top,
  output logic             empty,
  output logic             full,
  output logic             ovf
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] top_ptr_q, top_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == CNT_W'(DEPTH));
  assign top   = mem_q[top_ptr_q];
  assign ovf   = ovf_q;

  always_comb begin
    mem_d     = mem_q;
    top_ptr_d = top_ptr_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    if (push) begin
      // Pointer wraps modulo DEPTH, so a push into a full stack lands on the oldest slot.
      top_ptr_d        = top_ptr_q + PTR_W'(1);
      mem_d[top_ptr_d] = data_in;
      if (full) ovf_d = ENABLE;
      else      cnt_d = cnt_q + CNT_W'(1);
    end else if (pop && !empty) begin
      top_ptr_d = top_ptr_q - PTR_W'(1);
      cnt_d     = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      top_ptr_q <= '0;
      cnt_q     <= '0;
      ovf_q     <= DISABLE;
    end else begin
      mem_q     <= mem_d;
      top_ptr_q <= top_ptr_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
    end
  end

endmodule

// File: rtl/pc_ras.sv
// pc_ras: fetch-stage program counter with trap/call/jmp/ret/inc priority select and a RAS.
// Latency: one cycle; addr_out reflects the action sampled on the previous rising edge.
// Backpressure: en=0 holds PC, RAS and flags (trap still acts); no ready signalling.
// Ports: clk, reset (async active-low), en, jmp, call, ret, trap, addr_in ->
//        addr_out, ras_empty, ras_full, ras_ovf, ret_err.
`timescale 1ns/1ps
module pc_ras
  import pc_ras_pkg::*;
#(
  parameter int                    ADDR_WIDTH   = PC_ADDR_WIDTH,
  parameter int                    INC_STEP     = 1,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = ADDR_WIDTH'(DEF_RESET_VECTOR),
  parameter logic [ADDR_WIDTH-1:0] TRAP_VECTOR  = ADDR_WIDTH'(DEF_TRAP_VECTOR),
  parameter int                    RAS_DEPTH    = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  jmp,
  input  logic                  call,
  input  logic                  ret,
  input  logic                  trap,
  input  logic [ADDR_WIDTH-1:0] addr_in,
  output logic [ADDR_WIDTH-1:0] addr_out,
  output logic                  ras_empty,
  output logic                  ras_full,
  output logic                  ras_ovf,
  output logic                  ret_err
);

  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [ADDR_WIDTH-1:0] pc_inc;
  logic [ADDR_WIDTH-1:0] ras_top;
  logic                  ret_err_q, ret_err_d;
  logic                  ras_push, ras_pop;
  act_e                  act;

  // Sequential address doubles as the return address pushed on call.
  assign pc_inc = pc_q + ADDR_WIDTH'(INC_STEP);

  always_comb begin
    act       = select_action(en, trap, call, jmp, ret);
    pc_d      = pc_q;
    ret_err_d = DISABLE;
    ras_push  = DISABLE;
    ras_pop   = DISABLE;
    case (act)
      ACT_TRAP: pc_d = TRAP_VECTOR;
      ACT_CALL: begin
        pc_d     = addr_in;
        ras_push = ENABLE;
      end
      ACT_JMP:  pc_d = addr_in;
      ACT_RET: begin
        if (!ras_empty) begin
          pc_d    = ras_top;
          ras_pop = ENABLE;
        end else begin
          // Underflow falls back to a sequential advance and reports it.
          pc_d      = pc_inc;
          ret_err_d = ENABLE;
        end
      end
      ACT_INC:  pc_d = pc_inc;
      default:  ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q      <= RESET_VECTOR;
      ret_err_q <= DISABLE;
    end else begin
      pc_q      <= pc_d;
      ret_err_q <= ret_err_d;
    end
  end

  ras_stack #(
    .WIDTH (ADDR_WIDTH),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk     (clk),
    .reset   (reset),
    .push    (ras_push),
    .pop     (ras_pop),
    .data_in (pc_inc),
    .top     (ras_top),
    .empty   (ras_empty),
    .full    (ras_full),
    .ovf     (ras_ovf)
  );

  assign addr_out = pc_q;
  assign ret_err  = ret_err_q;

endmodule

// File: tb/tb_pc_ras.sv
// tb_pc_ras: scoreboard bench for pc_ras. Stimulus updates a queue-based reference
// model on every clock edge and pushes the expected outputs; a monitor pops and
// compares shortly after each clock edge or reset assertion.
`timescale 1ns/1ps
module tb_pc_ras;

  localparam int          DEPTH = 4;
  localparam logic [31:0] TRAPV = 32'h10;
  localparam logic [31:0] RSTV  = 32'h0;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        en = 1'b0, jmp = 1'b0, call = 1'b0, ret = 1'b0, trap = 1'b0;
  logic [31:0] addr_in = '0;
  logic [31:0] addr_out;
  logic        ras_empty, ras_full, ras_ovf, ret_err;

  pc_ras dut (
    .clk(clk), .reset(reset), .en(en), .jmp(jmp), .call(call), .ret(ret),
    .trap(trap), .addr_in(addr_in), .addr_out(addr_out), .ras_empty(ras_empty),
    .ras_full(ras_full), .ras_ovf(ras_ovf), .ret_err(ret_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic        empty;
    logic        full;
    logic        ovf;
    logic        rerr;
    string       tag;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: a plain bounded list of return addresses.
  logic [31:0] m_pc;
  logic [31:0] m_ras[$];
  logic        m_ovf;
  logic        m_rerr;

  function automatic void push_exp(input string tag);
    exp_t e;
    e.pc    = m_pc;
    e.empty = (m_ras.size() == 0);
    e.full  = (m_ras.size() == DEPTH);
    e.ovf   = m_ovf;
    e.rerr  = m_rerr;
    e.tag   = tag;
    sb.push_back(e);
  endfunction

  function automatic void model_reset();
    m_pc = RSTV;
    m_ras.delete();
    m_ovf = 1'b0;
    m_rerr = 1'b0;
  endfunction

  function automatic void model_edge(input logic e, input logic t, input logic c,
                                     input logic j, input logic r,
                                     input logic [31:0] a);
    m_rerr = 1'b0;
    if (t) m_pc = TRAPV;
    else if (!e) ;
    else if (c) begin
      m_ras.push_back(m_pc + 32'd1);
      if (m_ras.size() > DEPTH) begin
        void'(m_ras.pop_front());
        m_ovf = 1'b1;
      end
      m_pc = a;
    end else if (j) m_pc = a;
    else if (r) begin
      if (m_ras.size() > 0) m_pc = m_ras.pop_back();
      else begin
        m_pc = m_pc + 32'd1;
        m_rerr = 1'b1;
      end
    end else m_pc = m_pc + 32'd1;
  endfunction

  task automatic step(input logic e, input logic t, input logic c, input logic j,
                      input logic r, input logic [31:0] a, input string tag);
    @(negedge clk);
    en = e; trap = t; call = c; jmp = j; ret = r; addr_in = a;
    @(posedge clk);
    model_edge(e, t, c, j, r, a);
    push_exp(tag);
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  // Monitor: outputs settle shortly after a clock edge or an async reset.
  initial begin
    forever begin
      @(posedge clk or negedge reset);
      #0.5;
      while (sb.size() > 0) begin
        exp_t x;
        x = sb.pop_front();
        chk({x.tag, " addr_out"}, addr_out, x.pc);
        chk({x.tag, " ras_empty"}, 32'(ras_empty), 32'(x.empty));
        chk({x.tag, " ras_full"}, 32'(ras_full), 32'(x.full));
        chk({x.tag, " ras_ovf"}, 32'(ras_ovf), 32'(x.ovf));
        chk({x.tag, " ret_err"}, 32'(ret_err), 32'(x.rerr));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got timeout want finish");
    $fatal(1);
  end

  initial begin
    // Power-on reset, checked before the first clock edge.
    #2;
    model_reset();
    push_exp("reset");
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 10; i++) step(1, 0, 0, 0, 0, '0, "inc");
    for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 0, '0, "hold");

    step(1, 0, 1, 0, 0, 32'h33, "call33");
    step(1, 0, 0, 0, 0, '0, "inc_after_call");
    step(1, 0, 0, 0, 0, '0, "inc_after_call");
    step(1, 0, 0, 0, 1, '0, "ret_to_0b");

    for (int i = 1; i <= 5; i++) step(1, 0, 1, 0, 0, 32'(i) << 8, "nested_call");
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 1, '0, "nested_ret");
    step(1, 0, 0, 0, 1, '0, "ret_underflow");
    step(1, 0, 0, 0, 0, '0, "ret_err_drops");

    step(1, 0, 1, 0, 0, 32'h500, "call_before_prio");
    step(0, 1, 1, 1, 0, 32'h77, "trap_en0");
    step(1, 0, 1, 0, 1, 32'h40, "call_plus_ret");
    step(1, 0, 0, 1, 1, 32'h88, "jmp_plus_ret");
    step(0, 0, 1, 0, 1, 32'h99, "hold_ctrl");
    step(1, 0, 0, 1, 0, 32'hFFFF_FFFF, "jmp_allones");
    step(1, 0, 0, 0, 0, '0, "wrap_inc");

    // Asynchronous reset 1 ns after a call edge.
    step(1, 0, 1, 0, 0, 32'h1234, "call_pre_reset");
    #1;
    model_reset();
    push_exp("reset_mid_call");
    reset = 1'b0;
    @(negedge clk);
    en = 0; trap = 0; call = 0; jmp = 0; ret = 0;
    @(negedge clk);
    reset = 1'b1;
    step(1, 0, 0, 0, 0, '0, "first_after_reset");

    for (int i = 0; i < 400; i++) begin
      logic [31:0] a;
      a = (($urandom % 4) == 0) ? (32'hFFFF_FFF0 | 32'($urandom % 16)) : $urandom;
      step(($urandom % 8) != 0, ($urandom % 20) == 0, ($urandom % 4) == 0,
           ($urandom % 6) == 0, ($urandom % 2) == 0, a, "random");
    end

    @(negedge clk);
    @(negedge clk);
    if (sb.size() != 0) begin
      errors++;
      checks++;
      $display("FAIL scoreboard_drain: got %0d pending want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pc_ras.md
Name: pc_ras

Overview:
- Next-generation program counter with a parametrised width, increment step, reset/trap vectors and a return-address stack (RAS) of configurable depth.
- Supports:
  - sequential increment
  - absolute jump
  - call (push return address + jump)
  - return (pop + jump)
  - trap redirect
- Sits at the head of the fetch stage and drives the instruction-memory address.

Parameters:
- ADDR_WIDTH, 32, width of PC and all address paths.
- INC_STEP, 1, value added to PC on a sequential advance.
- RESET_VECTOR, 0, PC value while reset is asserted and after release.
- TRAP_VECTOR, 32'h10, PC value loaded on trap.
- RAS_DEPTH, 4, number of RAS entries; power of two, ≥2.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset; asserted at 0.
- en  input  1  advance enable; 0 = hold (trap excepted).
- jmp  input  1  load addr_in.
- call  input  1  push addr_out+INC_STEP, load addr_in.
- ret  input  1  pop RAS top into PC.
- trap  input  1  load TRAP_VECTOR.
- addr_in  input  ADDR_WIDTH  jump/call target.
- addr_out  output  ADDR_WIDTH  current PC, registered.
- ras_empty  output  1  RAS holds 0 entries.
- ras_full  output  1  RAS holds RAS_DEPTH entries.
- ras_ovf  output  1  sticky; set when a push discards the oldest entry.
- ret_err  output  1  one-cycle pulse; ret selected with RAS empty.

Behaviour:
- Reset (reset=0, asynchronous):
  - addr_out=RESET_VECTOR; RAS count=0; ras_empty=1; ras_full=0; ras_ovf=0; ret_err=0.
  - Takes effect immediately, mid-operation included; pending call/ret is discarded.
  - First advance occurs on the first rising edge with reset=1.
- Each rising edge selects exactly one action by priority, trap > call > jmp > ret > inc.
- trap:
  - PC<=TRAP_VECTOR; RAS untouched.
  - Acts even when en=0.
- With en=0 and no trap: PC, RAS, flags hold; ret_err=0.
- call (en=1):
  - PC<=addr_in; push (addr_out+INC_STEP) mod 2^ADDR_WIDTH.
  - RAS full: circular buffer overwrites the oldest entry; count stays RAS_DEPTH; ras_ovf<=1 (sticky until reset).
- jmp (en=1): PC<=addr_in; RAS untouched.
- ret (en=1):
  - RAS non-empty: PC<=top; count decrements.
  - RAS empty: behaves as inc; ret_err=1 for that cycle only.
- inc (en=1, no control): PC<=(PC+INC_STEP) mod 2^ADDR_WIDTH; wrap from all-ones silently.
- Single-cycle latency for every action: new addr_out is visible after the edge on which the control was sampled.
- Simultaneous controls:
  - Only the winner acts; losers have no side effect.
  - E.g. call+ret pushes, does not pop.
  - E.g. jmp+ret does not pop.
- Flag timing:
  - ras_empty/ras_full are combinational from the registered count.
  - ret_err is registered.
- RAS pointer:
  - top pointer is log2(RAS_DEPTH) bits, wraps modulo RAS_DEPTH.
  - count is log2(RAS_DEPTH)+1 bits, saturates at RAS_DEPTH.

Decomposition:
- Shared header pc.vh:
  - PC_ADDR_WIDTH, PC_ADDR_WIDTH_VECTOR
  - ENABLE/DISABLE
  - default RESET_VECTOR/TRAP_VECTOR
  - action-select encodings (ACT_TRAP, ACT_CALL, ACT_JMP, ACT_RET, ACT_INC)
- Sub-module ras_stack:
  - parametrised circular LIFO (WIDTH, DEPTH).
  - push/pop/data_in/top/empty/full/ovf.
  - same clk/reset convention.
- pc_ras holds the priority selector and the PC register.

Test Plan:
- Reset released, en=1, no controls, 10 cycles -> addr_out=10; hold en=0 10 cycles -> addr_out stays 10.
- At PC=10: call addr_in=0x33 -> addr_out=0x33, ras_empty=0. Then 2 incs -> 0x35. Then ret -> addr_out=0x0B, ras_empty=1.
- RAS_DEPTH=4:
  - 5 nested calls to targets 0x100,0x200,0x300,0x400,0x500 -> ras_full=1, ras_ovf=1.
  - 4 rets -> 0x401,0x301,0x201,0x101.
  - 5th ret -> PC+1, ret_err pulse, ras_empty=1.
- Priority:
  - trap+call+jmp with en=0 -> addr_out=0x10, RAS unchanged.
  - call+ret with addr_in=0x40 -> addr_out=0x40, push occurs, no pop.
- Wrap: jmp to 0xFFFFFFFF then inc -> addr_out=0x0, no flag change.
- Reset mid-call: reset=0 asserted 1 ns after call edge, between clock edges -> addr_out=0 immediately (checked #1), ras_empty=1, ras_ovf=0.
